pam_rx_frame_ctrl: RTL

Frame-level controller for the PAM receiver. It sequences the m-sequence synchronizer (search enable, lock, timeout/retry) and gates the post-sync sample stream into the demodulator through a small FIFO. It counts payload samples and frames, and reports done and error status. It sits between the AD front end / synchronizer and the PAM demodulator.

---
 rtl/pam_rx_frame_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pam_rx_frame_ctrl.sv
// Frame-level controller for the PAM receiver: sequences sync search, gates the aligned
// sample stream into the demodulator via a show-ahead FIFO. Optional macro: PAM_RX_ERR_CNT_EN.
module pam_rx_frame_ctrl #(
  parameter int AD_CVER_WIDTH   = 12,
  parameter int LENGTH_DATA     = 1024,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int GAP_CYCLES      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_num_frames,
  output logic                       sync_search_en,
  input  logic                       sync_lock,
  input  logic                       ad_valid,
  input  logic [AD_CVER_WIDTH-1:0]   ad_data,
  input  logic                       demod_ready,
  output logic                       demod_valid,
  output logic [AD_CVER_WIDTH-1:0]   demod_data,
  output logic                       demod_last,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       run_done,
  output logic                       timeout_err,
  output logic                       ovf_err,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic [15:0]                err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (LENGTH_DATA > 1) ? $clog2(LENGTH_DATA) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DW = AD_CVER_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_PAYLOAD, S_GAP, S_DONE} state_t;

  state_t state, state_nxt;

  logic [TW-1:0]              tmo_cnt;
  logic [SW-1:0]              smp_cnt;
  logic [GW-1:0]              gap_cnt;
  logic [FRAME_CNT_WIDTH-1:0] num_frames_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_nxt;

  logic start_acc, tmo_hit, smp_last, gap_elapsed;
  logic push_req, push, pop, drop, frame_end, last_frame;

  // FIFO storage and pointers (one extra pointer bit distinguishes full from empty)
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fifo_count;
  logic          fifo_empty, fifo_full;
  logic [DW-1:0] rd_word;

  assign start_acc     = (state == S_IDLE) && cfg_start && !cfg_abort;
  assign tmo_hit       = (state == S_SEARCH) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign smp_last      = (smp_cnt == SW'(LENGTH_DATA - 1));
  assign gap_elapsed   = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign push_req      = (state == S_PAYLOAD) && ad_valid && !cfg_abort;
  assign frame_end     = (state == S_GAP) && gap_elapsed && fifo_empty && !cfg_abort;
  assign frame_cnt_nxt = frame_cnt + 1'b1;
  assign last_frame    = (num_frames_q != '0) && (frame_cnt_nxt == num_frames_q);

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && demod_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (cfg_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (cfg_start) state_nxt = S_SEARCH;
        S_SEARCH:  if (sync_lock) state_nxt = S_PAYLOAD;
        S_PAYLOAD: if (push_req && smp_last) state_nxt = S_GAP;
        S_GAP:     if (frame_end) state_nxt = last_frame ? S_DONE : S_SEARCH;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != S_IDLE);
    sync_search_en = (state == S_SEARCH);
    run_done       = (state == S_DONE);
  end

  // Per-state counters restart from zero on every state entry and on abort
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt <= '0;
      smp_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (cfg_abort || state != S_SEARCH || sync_lock || tmo_hit) tmo_cnt <= '0;
      else                                                        tmo_cnt <= tmo_cnt + 1'b1;

      if (cfg_abort || state != S_PAYLOAD) smp_cnt <= '0;
      else if (push_req)                   smp_cnt <= smp_last ? '0 : smp_cnt + 1'b1;

      if (cfg_abort || state != S_GAP) gap_cnt <= '0;
      else if (!gap_elapsed)           gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      timeout_err  <= 1'b0;
      ovf_err      <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      num_frames_q <= '0;
    end else begin
      timeout_err <= tmo_hit && !sync_lock && !cfg_abort;
      ovf_err     <= drop;
      frame_done  <= frame_end;
      if (start_acc) begin
        num_frames_q <= cfg_num_frames;
        frame_cnt    <= '0;
      end else if (frame_end) begin
        frame_cnt <= frame_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (cfg_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; outputs are masked while empty, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {smp_last, ad_data};
  end

  assign rd_word     = mem[rd_ptr[AW-1:0]];
  assign demod_valid = !fifo_empty;
  assign demod_data  = fifo_empty ? '0 : rd_word[AD_CVER_WIDTH-1:0];
  assign demod_last  = fifo_empty ? 1'b0 : rd_word[DW-1];

`ifdef PAM_RX_ERR_CNT_EN
  logic [7:0] tmo_ecnt, ovf_ecnt;

  // Saturating error tallies survive an abort so software can still read them afterwards
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_ecnt <= '0;
      ovf_ecnt <= '0;
    end else if (start_acc) begin
      tmo_ecnt <= '0;
      ovf_ecnt <= '0;
    end else begin
      if (timeout_err && tmo_ecnt != 8'hFF) tmo_ecnt <= tmo_ecnt + 1'b1;
      if (ovf_err && ovf_ecnt != 8'hFF)     ovf_ecnt <= ovf_ecnt + 1'b1;
    end
  end

  assign err_cnt = {tmo_ecnt, ovf_ecnt};
`else
  assign err_cnt = '0;
`endif

endmodule
